// File: rtl/psum_rearrange_ctrl.sv
// Sequencer for the psum rearrange buffer: scatters the pixel-interleaved psum stream
// channel-major into the buffer, then streams the buffer back out in address order.
module psum_rearrange_ctrl #(
   parameter int FMAP_W       = 24,
   parameter int FMAP_H       = 24,
   parameter int FMAP_CH      = 6,
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 8,
   parameter int CLEAR_CYCLES = 4096
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              buf_write_en,
   output logic              buf_data_in_valid,
   output logic [ADDR_W-1:0] buf_write_addr,
   output logic [DATA_W-1:0] buf_data_in,
   output logic [ADDR_W-1:0] buf_read_addr,
   input  logic [DATA_W-1:0] buf_data_out,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   localparam int TOTAL = FMAP_W * FMAP_H * FMAP_CH;
   localparam int PLANE = FMAP_W * FMAP_H;
   localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

   localparam logic [ADDR_W-1:0] PLANE_A    = ADDR_W'(PLANE);
   localparam logic [ADDR_W-1:0] PLANE_LAST = ADDR_W'(PLANE - 1);
   localparam logic [ADDR_W-1:0] CH_LAST    = ADDR_W'(FMAP_CH - 1);
   localparam logic [ADDR_W:0]   TOTAL_P    = (ADDR_W + 1)'(TOTAL);
   localparam logic [ADDR_W:0]   LAST_P     = (ADDR_W + 1)'(TOTAL - 1);
   localparam logic [CLR_W-1:0]  CLR_LAST   = CLR_W'(CLEAR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DONE
   } state_t;

   state_t              state;
   logic [CLR_W-1:0]    clr_cnt;
   logic [ADDR_W-1:0]   ch_cnt;
   logic [ADDR_W-1:0]   ch_off;
   logic [ADDR_W-1:0]   pix_base;
   logic [ADDR_W:0]     rd_ptr;
   logic                in_flight;
   logic                in_flight_last;

   logic [1:0][DATA_W-1:0] fifo_data;
   logic [1:0]             fifo_last;
   logic                   fifo_wr;
   logic                   fifo_rd;
   logic [1:0]             fifo_count;

   logic       wr_fire;
   logic       wr_final;
   logic       pop;
   logic [2:0] occ;
   logic       issue;

   assign wr_fire  = (state == S_WRITE) && in_valid;
   assign wr_final = wr_fire && (ch_cnt == CH_LAST) && (pix_base == PLANE_LAST);
   assign pop      = (fifo_count != 2'd0) && out_ready;
   // A slot popped this cycle is already free, which keeps one element per cycle flowing.
   assign occ      = {1'b0, fifo_count} + {2'b0, in_flight} - {2'b0, pop};
   assign issue    = (state == S_READ) && (rd_ptr < TOTAL_P) && (occ < 3'd2);

   assign busy              = (state != S_IDLE);
   assign done              = (state == S_DONE);
   assign in_ready          = (state == S_WRITE);
   assign buf_write_en      = wr_fire;
   assign buf_data_in_valid = wr_fire;
   assign buf_write_addr    = wr_fire ? (pix_base + ch_off) : '0;
   assign buf_data_in       = wr_fire ? in_data : '0;
   assign buf_read_addr     = rd_ptr[ADDR_W-1:0];
   assign out_valid         = (fifo_count != 2'd0);
   assign out_data          = fifo_data[fifo_rd];
   assign out_last          = out_valid && fifo_last[fifo_rd];

   // Phase sequencing plus the write scatter counters and the read issue pointer.
   // Channel is the fastest-moving input index, so its offset steps by a whole plane
   // while the pixel base steps by one each time the channel count wraps.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_CLEAR;
         clr_cnt        <= '0;
         ch_cnt         <= '0;
         ch_off         <= '0;
         pix_base       <= '0;
         rd_ptr         <= '0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
      end else begin
         in_flight      <= issue;
         in_flight_last <= issue && (rd_ptr == LAST_P);
         case (state)
            S_CLEAR: begin
               if (clr_cnt == CLR_LAST) begin
                  state <= S_IDLE;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (start) begin
                  state    <= S_WRITE;
                  ch_cnt   <= '0;
                  ch_off   <= '0;
                  pix_base <= '0;
                  rd_ptr   <= '0;
               end
            end
            S_WRITE: begin
               if (wr_fire) begin
                  if (ch_cnt == CH_LAST) begin
                     ch_cnt   <= '0;
                     ch_off   <= '0;
                     pix_base <= pix_base + 1'b1;
                  end else begin
                     ch_cnt <= ch_cnt + 1'b1;
                     ch_off <= ch_off + PLANE_A;
                  end
               end
               if (wr_final) begin
                  state <= S_READ;
               end
            end
            S_READ: begin
               if (issue) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
               if (pop && fifo_last[fifo_rd]) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_CLEAR;
            end
         endcase
      end
   end

   // Two-entry output FIFO fed by the buffer's one-cycle read return.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fifo_data  <= '0;
         fifo_last  <= '0;
         fifo_wr    <= 1'b0;
         fifo_rd    <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (in_flight) begin
            fifo_data[fifo_wr] <= buf_data_out;
            fifo_last[fifo_wr] <= in_flight_last;
            fifo_wr            <= ~fifo_wr;
         end
         if (pop) begin
            fifo_rd <= ~fifo_rd;
         end
         case ({in_flight, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_rearrange_ctrl.sv
// Scoreboard bench for psum_rearrange_ctrl: a behavioural buffer plus a reference
// model of the channel-major scatter predict every buffer write and every output element.
module tb_psum_rearrange_ctrl;

   localparam int W     = 24;
   localparam int H     = 24;
   localparam int CH    = 6;
   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int CLR   = 4096;
   localparam int TOTAL = W * H * CH;
   localparam int PLANE = W * H;

   logic          clock;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          buf_write_en;
   logic          buf_data_in_valid;
   logic [AW-1:0] buf_write_addr;
   logic [DW-1:0] buf_data_in;
   logic [AW-1:0] buf_read_addr;
   logic [DW-1:0] buf_data_out;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;

   psum_rearrange_ctrl #(
      .FMAP_W(W), .FMAP_H(H), .FMAP_CH(CH), .ADDR_W(AW), .DATA_W(DW), .CLEAR_CYCLES(CLR)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .buf_write_en(buf_write_en), .buf_data_in_valid(buf_data_in_valid),
      .buf_write_addr(buf_write_addr), .buf_data_in(buf_data_in),
      .buf_read_addr(buf_read_addr), .buf_data_out(buf_data_out),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural buffer: one-cycle read latency, zeroed while reset is held.
   logic [DW-1:0] bram [4096];
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4096; i++) bram[i] <= '0;
         buf_data_out <= '0;
      end else begin
         if (buf_write_en && buf_data_in_valid) bram[buf_write_addr] <= buf_data_in;
         buf_data_out <= bram[buf_read_addr];
      end
   end

   typedef struct { int addr; int data; } wr_exp_t;
   typedef struct { int data; bit last; } rd_exp_t;

   wr_exp_t wr_q[$];
   rd_exp_t rd_q[$];
   int      model_mem [TOTAL];
   int      wr_hist [TOTAL];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int out_count = 0;
   int wr_count = 0;
   int first_out_cyc = -1;
   int last_out_cyc = 0;
   int last_wr_cyc = 0;
   bit pass_done = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference scatter: element idx is (row, col, channel) with channel fastest.
   function automatic int refAddr(input int idx);
      int c, pix, r, x;
      c   = idx % CH;
      pix = idx / CH;
      r   = pix / W;
      x   = pix % W;
      return c * PLANE + r * W + x;
   endfunction

   // Monitor: pops expectations whenever the DUT writes the buffer or hands over an element.
   initial begin : monitor
      bit      prev_stall = 0;
      bit      prev_last_hs = 0;
      bit      prev_done = 0;
      int      prev_data = 0;
      int      prev_lastv = 0;
      wr_exp_t we;
      rd_exp_t re;
      forever begin
         @(negedge clock);
         #1;
         if (!reset) begin
            prev_stall   = 0;
            prev_last_hs = 0;
            prev_done    = 0;
         end else begin
            if (buf_write_en || wr_q.size() != 0) begin
               checkOutput("write_en", int'(buf_write_en), int'(wr_q.size() != 0));
               if (wr_q.size() != 0) begin
                  we = wr_q.pop_front();
                  if (buf_write_en) begin
                     checkOutput("write_addr", int'(buf_write_addr), we.addr);
                     checkOutput("write_data", int'(buf_data_in), we.data);
                     checkOutput("write_data_valid", int'(buf_data_in_valid), 1);
                     if (wr_count < TOTAL) wr_hist[wr_count] = int'(buf_write_addr);
                     wr_count++;
                     last_wr_cyc = cyc;
                  end
               end
            end
            if (prev_stall) begin
               checkOutput("stall_valid_held", int'(out_valid), 1);
               checkOutput("stall_data_held", int'(out_data), prev_data);
               checkOutput("stall_last_held", int'(out_last), prev_lastv);
            end
            if (out_valid) begin
               if (rd_q.size() == 0) begin
                  checkOutput("spurious_out_valid", int'(out_valid), 0);
               end else if (out_ready) begin
                  re = rd_q.pop_front();
                  checkOutput("out_data", int'(out_data), re.data);
                  checkOutput("out_last", int'(out_last), int'(re.last));
                  if (out_count == 0) first_out_cyc = cyc;
                  out_count++;
                  last_out_cyc = cyc;
               end
            end
            if (done || prev_last_hs) checkOutput("done_after_last", int'(done), int'(prev_last_hs));
            if (prev_done) checkOutput("idle_after_done", int'(busy), 0);
            if (done) pass_done = 1;
            prev_stall   = out_valid && !out_ready;
            prev_data    = int'(out_data);
            prev_lastv   = int'(out_last);
            prev_last_hs = out_valid && out_ready && out_last;
            prev_done    = done;
         end
      end
   end

   // Releases reset and checks the clear window; start is pulsed partway through it.
   task automatic waitClear();
      int bad = 0;
      @(negedge clock);
      reset = 1'b1;
      for (int j = 0; j < CLR - 1; j++) begin
         @(posedge clock);
         #1 start = (j == 10);
         @(negedge clock);
         if (!busy || in_ready || out_valid || buf_write_en) bad++;
      end
      checkOutput("clear_window_violations", bad, 0);
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      checkOutput("idle_after_clear_busy", int'(busy), 0);
      repeat (3) @(negedge clock);
      checkOutput("start_in_clear_ignored", int'(busy), 0);
   endtask

   task automatic applyStimulus(input int gap_pct, input int stall_pct, input bit noise,
                                input bit rand_data, input int abort_at);
      int idx = 0;
      int budget = 0;
      int cur_data;
      bit wr_done = 0;
      bit check_drop = 0;
      bit aborted = 0;
      out_count = 0;
      wr_count = 0;
      first_out_cyc = -1;
      pass_done = 0;
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      forever begin
         cur_data  = rand_data ? int'($urandom_range(255)) : (idx % 256);
         in_valid  = !wr_done && (int'($urandom_range(99)) >= gap_pct);
         in_data   = DW'(cur_data);
         out_ready = (int'($urandom_range(99)) >= stall_pct);
         start     = noise && ($urandom_range(15) == 0);
         if (abort_at > 0 && out_count >= abort_at) begin
            reset = 1'b0;
            #1;
            checkOutput("abort_out_valid", int'(out_valid), 0);
            checkOutput("abort_out_data", int'(out_data), 0);
            checkOutput("abort_busy", int'(busy), 1);
            checkOutput("abort_in_ready", int'(in_ready), 0);
            checkOutput("abort_write_en", int'(buf_write_en), 0);
            rd_q.delete();
            wr_q.delete();
            aborted = 1;
            break;
         end
         @(negedge clock);
         if (check_drop) begin
            checkOutput("in_ready_drop", int'(in_ready), 0);
            check_drop = 0;
         end
         if (!wr_done) begin
            if (in_ready != 1'b1) checkOutput("in_ready_write", int'(in_ready), 1);
            if (in_valid && in_ready) begin
               wr_q.push_back('{addr: refAddr(idx), data: cur_data});
               model_mem[refAddr(idx)] = cur_data;
               idx++;
               if (idx == TOTAL) begin
                  wr_done = 1;
                  check_drop = 1;
                  for (int k = 0; k < TOTAL; k++)
                     rd_q.push_back('{data: model_mem[k], last: (k == TOTAL - 1)});
               end
            end
         end
         #2;
         if (pass_done) break;
         budget++;
         if (budget >= 40000) begin
            checkOutput("pass_timeout", budget, 0);
            break;
         end
         @(posedge clock);
         #1;
      end
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      if (!aborted) begin
         checkOutput("pass_out_count", out_count, TOTAL);
         checkOutput("pass_write_count", wr_count, TOTAL);
         checkOutput("pass_rd_q_empty", rd_q.size(), 0);
      end
   endtask

   initial begin : main
      reset     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      checkOutput("reset_busy", int'(busy), 1);
      checkOutput("reset_in_ready", int'(in_ready), 0);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_done", int'(done), 0);
      repeat (3) @(posedge clock);
      waitClear();

      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("first_out_latency", first_out_cyc - last_wr_cyc, 3);
      checkOutput("stream_span", last_out_cyc - first_out_cyc, TOTAL - 1);
      checkOutput("addr_idx0", wr_hist[0], 0);
      checkOutput("addr_idx1", wr_hist[1], 576);
      checkOutput("addr_idx5", wr_hist[5], 2880);
      checkOutput("addr_idx6", wr_hist[6], 1);
      checkOutput("addr_idx144", wr_hist[144], 24);
      checkOutput("addr_idx3455", wr_hist[3455], 3455);

      applyStimulus(40, 50, 0, 0, 0);
      applyStimulus(30, 50, 1, 1, 0);
      applyStimulus(0, 0, 0, 1, 1000);
      waitClear();
      applyStimulus(20, 30, 0, 1, 0);

      repeat (3) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #3000000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
